// File: rtl/rvv_pkg.sv
// Shared RVV types and helpers: func3/func6 encodings, vtype layout,
// OPCFG zimm layout, vl width, register-group masks and VLMAX.
package rvv_pkg;

  localparam logic [6:0] OpcodeVec = 7'b1010111;

  typedef enum logic [2:0] {
    OPIVV = 3'b000,
    OPFVV = 3'b001,
    OPMVV = 3'b010,
    OPIVI = 3'b011,
    OPIVX = 3'b100,
    OPFVF = 3'b101,
    OPMVX = 3'b110,
    OPCFG = 3'b111
  } opcodev_func3_e;

  typedef enum logic [5:0] {
    OPVADD   = 6'b000000,
    OPVSUB   = 6'b000010,
    OPVRSUB  = 6'b000011,
    OPVMINU  = 6'b000100,
    OPVMIN   = 6'b000101,
    OPVMAXU  = 6'b000110,
    OPVMAX   = 6'b000111,
    OPVAND   = 6'b001001,
    OPVOR    = 6'b001010,
    OPVXOR   = 6'b001011,
    OPVMERGE = 6'b010111,
    OPVSLL   = 6'b100101,
    OPVSRL   = 6'b101000,
    OPVSRA   = 6'b101001
  } opcodev_func6_e;

  typedef enum logic [2:0] {
    EW8  = 3'd0,
    EW16 = 3'd1,
    EW32 = 3'd2,
    EW64 = 3'd3
  } vew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_1_8  = 3'd5,
    LMUL_1_4  = 3'd6,
    LMUL_1_2  = 3'd7
  } vlmul_e;

  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } vtype_t;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    vlmul_e     vlmul;
  } vtype_zimm_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } hold_state_e;

  localparam vtype_t VtypeVill = '{
    vill: 1'b1, vma: 1'b0, vta: 1'b0,
    vsew: EW8, vlmul: LMUL_1
  };

  function automatic int unsigned VlWidth(
    input int unsigned vlen
  );
    return $clog2(vlen) + 1;
  endfunction

  function automatic logic [31:0] group_mask(
    input logic [4:0] vreg,
    input vlmul_e     vlmul
  );
    logic [31:0] m;
    case (vlmul)
      LMUL_2:  m = 32'h0000_0003;
      LMUL_4:  m = 32'h0000_000F;
      LMUL_8:  m = 32'h0000_00FF;
      default: m = 32'h0000_0001;
    endcase
    return m << vreg;
  endfunction

  function automatic logic [31:0] vlmax(
    input logic [2:0]  vsew,
    input vlmul_e      vlmul,
    input int unsigned vlen
  );
    logic [31:0] base;
    logic [2:0]  l;
    l    = vlmul;
    base = 32'(vlen) >> (32'd3 + 32'(vsew));
    if (!l[2]) return base << l[1:0];
    return base >> (32'd8 - 32'(l));
  endfunction

  function automatic logic func6_valid(
    input logic [5:0] f6
  );
    case (f6)
      OPVADD, OPVSUB, OPVRSUB,
      OPVMINU, OPVMIN, OPVMAXU, OPVMAX,
      OPVAND, OPVOR, OPVXOR,
      OPVMERGE, OPVSLL, OPVSRL, OPVSRA:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vinsn_issue_ctrl_inflight_fifo.sv
// In-flight op FIFO: i_push/i_data enqueue, i_pop dequeues the head,
// o_full/o_empty report occupancy, o_head shows the oldest entry.
module inflight_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_head
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vinsn_issue_ctrl.sv
// Vector issue controller: insn_* feed in, issue_* op out to the VFU,
// done_i retires in-flight ops, vtype_o/vl_o hold vsetvli state.
module vinsn_issue_ctrl
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned NrInflight = 4,
  localparam int unsigned VlW       = VlWidth(VLEN)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           insn_valid_i,
  output logic           insn_ready_o,
  input  logic [31:0]    insn_i,
  input  logic [63:0]    rs1_i,
  output logic           issue_valid_o,
  input  logic           issue_ready_i,
  output logic [5:0]     issue_func6_o,
  output logic [2:0]     issue_func3_o,
  output logic           issue_vm_o,
  output logic [4:0]     issue_vs1_o,
  output logic [4:0]     issue_vs2_o,
  output logic [4:0]     issue_vd_o,
  output logic [63:0]    issue_scalar_o,
  output vtype_t         issue_vtype_o,
  output logic [VlW-1:0] issue_vl_o,
  input  logic           done_i,
  output logic           illegal_o,
  output vtype_t         vtype_o,
  output logic [VlW-1:0] vl_o
);

  hold_state_e    r_state;
  logic [31:0]    r_insn;
  logic [63:0]    r_rs1;
  vtype_t         r_vtype;
  logic [VlW-1:0] r_vl;
  logic [31:0]    r_busy;

  logic        w_held;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [5:0]  w_f6;
  logic        w_vm;
  logic [4:0]  w_vs1;
  logic [4:0]  w_vs2;
  logic [4:0]  w_vd;

  assign w_held   = (r_state == ST_HELD);
  assign w_opcode = r_insn[6:0];
  assign w_vd     = r_insn[11:7];
  assign w_f3     = r_insn[14:12];
  assign w_vs1    = r_insn[19:15];
  assign w_vs2    = r_insn[24:20];
  assign w_vm     = r_insn[25];
  assign w_f6     = r_insn[31:26];

  // vsetivli carries a 10-bit zimm; widen so both forms share a layout
  vtype_zimm_t    w_zimm;
  logic [31:0]    w_cfg_vlmax;
  logic [63:0]    w_avl;
  logic           w_cfg_vill;
  logic [VlW-1:0] w_cfg_vl;
  vtype_t         w_cfg_vtype;
  logic           w_is_cfg;

  assign w_zimm = r_insn[31] ?
    vtype_zimm_t'({1'b0, r_insn[29:20]}) :
    vtype_zimm_t'(r_insn[30:20]);

  assign w_cfg_vlmax =
    vlmax(w_zimm.vsew, w_zimm.vlmul, VLEN);

  always_comb begin
    w_avl = r_rs1;
    if (r_insn[31])
      w_avl = {59'd0, w_vs1};
    else if (w_vs1 == 5'd0)
      w_avl = {32'd0, w_cfg_vlmax};
  end

  assign w_cfg_vill =
    (w_zimm.vlmul == LMUL_RSVD) ||
    (w_zimm.rsvd != 3'd0) ||
    (w_cfg_vlmax == 32'd0);

  assign w_cfg_vl =
    (w_avl < {32'd0, w_cfg_vlmax}) ?
    w_avl[VlW-1:0] : w_cfg_vlmax[VlW-1:0];

  assign w_cfg_vtype = '{
    vill:  1'b0,
    vma:   w_zimm.vma,
    vta:   w_zimm.vta,
    vsew:  vew_e'(w_zimm.vsew),
    vlmul: w_zimm.vlmul
  };

  // insn[31:30]==2'b10 (vsetvl) is not a config op and falls to illegal
  assign w_is_cfg =
    (w_opcode == OpcodeVec) &&
    (w_f3 == OPCFG) &&
    (!r_insn[31] || r_insn[30]);

  logic        w_is_vv;
  logic        w_is_vx;
  logic        w_is_vi;
  logic        w_f3_ok;
  logic [4:0]  w_gm1;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_arith;
  logic [31:0] w_need;
  logic [31:0] w_vd_mask;
  logic        w_hazard;

  assign w_is_vv = (w_f3 == OPIVV);
  assign w_is_vx = (w_f3 == OPIVX);
  assign w_is_vi = (w_f3 == OPIVI);
  assign w_f3_ok = w_is_vv || w_is_vx || w_is_vi;

  always_comb begin
    case (r_vtype.vlmul)
      LMUL_2:  w_gm1 = 5'd1;
      LMUL_4:  w_gm1 = 5'd3;
      LMUL_8:  w_gm1 = 5'd7;
      default: w_gm1 = 5'd0;
    endcase
  end

  assign w_misalign =
    (|(w_vd & w_gm1)) ||
    (|(w_vs2 & w_gm1)) ||
    (w_is_vv && |(w_vs1 & w_gm1));

  assign w_illegal = !w_is_cfg && (
    (w_opcode != OpcodeVec) ||
    !w_f3_ok ||
    !func6_valid(w_f6) ||
    r_vtype.vill ||
    w_misalign ||
    (!w_vm && (w_vd == 5'd0)));

  assign w_arith = !w_is_cfg && !w_illegal;

  assign w_vd_mask = group_mask(w_vd, r_vtype.vlmul);

  assign w_need =
    w_vd_mask |
    group_mask(w_vs2, r_vtype.vlmul) |
    (w_is_vv ? group_mask(w_vs1, r_vtype.vlmul) : 32'd0) |
    (w_vm ? 32'd0 : 32'd1);

  // Only the registered busy mask is consulted, so a release is seen
  // one cycle after done_i
  assign w_hazard = |(r_busy & w_need);

  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_issue_hs;
  logic        w_retire;
  logic        w_accept;
  logic        w_pop;

  assign issue_valid_o =
    w_held && w_arith && !w_hazard && !w_full;

  assign w_issue_hs = issue_valid_o && issue_ready_i;
  assign w_retire   =
    w_held && (w_is_cfg || w_illegal || w_issue_hs);
  assign insn_ready_o = !w_held || w_retire;
  assign w_accept     = insn_valid_i && insn_ready_o;
  assign w_pop        = done_i && !w_empty;

  inflight_fifo #(
    .Width (32),
    .Depth (NrInflight)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_issue_hs),
    .i_data  (w_vd_mask),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_EMPTY;
      r_insn  <= '0;
      r_rs1   <= '0;
      r_vtype <= VtypeVill;
      r_vl    <= '0;
      r_busy  <= '0;
    end else begin
      if (w_accept) begin
        r_state <= ST_HELD;
        r_insn  <= insn_i;
        r_rs1   <= rs1_i;
      end else if (w_retire) begin
        r_state <= ST_EMPTY;
      end
      if (w_held && w_is_cfg) begin
        if (w_cfg_vill) begin
          r_vtype <= VtypeVill;
          r_vl    <= '0;
        end else begin
          r_vtype <= w_cfg_vtype;
          r_vl    <= w_cfg_vl;
        end
      end
      r_busy <=
        (r_busy & ~(w_pop ? w_head : 32'd0)) |
        (w_issue_hs ? w_vd_mask : 32'd0);
    end
  end

  always_comb begin
    issue_scalar_o = '0;
    unique case (1'b1)
      w_is_vx: issue_scalar_o = r_rs1;
      w_is_vi: issue_scalar_o = {{59{w_vs1[4]}}, w_vs1};
      default: issue_scalar_o = '0;
    endcase
  end

  assign issue_func6_o = w_f6;
  assign issue_func3_o = w_f3;
  assign issue_vm_o    = w_vm;
  assign issue_vs1_o   = w_vs1;
  assign issue_vs2_o   = w_vs2;
  assign issue_vd_o    = w_vd;
  assign issue_vtype_o = r_vtype;
  assign issue_vl_o    = r_vl;
  assign illegal_o     = w_held && w_illegal;
  assign vtype_o       = r_vtype;
  assign vl_o          = r_vl;

endmodule

// File: tb/tb_vinsn_issue_ctrl.sv
// Directed bench for vinsn_issue_ctrl: config, hazards, FIFO limits,
// operand encoding, legality and reset, with hand-computed expectations.
module tb_vinsn_issue_ctrl;
  import rvv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [63:0] rs1;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  f6_o;
  logic [2:0]  f3_o;
  logic        vm_o;
  logic [4:0]  vs1_o;
  logic [4:0]  vs2_o;
  logic [4:0]  vd_o;
  logic [63:0] scalar_o;
  vtype_t      ivtype;
  logic [7:0]  ivl;
  logic        done;
  logic        illegal;
  vtype_t      vtype;
  logic [7:0]  vl;

  int n_chk  = 0;
  int n_fail = 0;
  int n_iss  = 0;
  int base;

  always #5 clk = ~clk;

  vinsn_issue_ctrl #(
    .VLEN       (128),
    .NrInflight (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .insn_valid_i   (insn_valid),
    .insn_ready_o   (insn_ready),
    .insn_i         (insn),
    .rs1_i          (rs1),
    .issue_valid_o  (issue_valid),
    .issue_ready_i  (issue_ready),
    .issue_func6_o  (f6_o),
    .issue_func3_o  (f3_o),
    .issue_vm_o     (vm_o),
    .issue_vs1_o    (vs1_o),
    .issue_vs2_o    (vs2_o),
    .issue_vd_o     (vd_o),
    .issue_scalar_o (scalar_o),
    .issue_vtype_o  (ivtype),
    .issue_vl_o     (ivl),
    .done_i         (done),
    .illegal_o      (illegal),
    .vtype_o        (vtype),
    .vl_o           (vl)
  );

  always @(posedge clk)
    if (rst_n && issue_valid && issue_ready)
      n_iss++;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [10:0] zi(
    input logic [2:0] sew,
    input logic [2:0] lmul
  );
    return {5'b0, sew, lmul};
  endfunction

  function automatic logic [31:0] vcfg(
    input logic [4:0]  rs1f,
    input logic [10:0] z
  );
    return {1'b0, z, rs1f, 3'b111, 5'd1, 7'h57};
  endfunction

  function automatic logic [31:0] vcfgi(
    input logic [4:0]  uimm,
    input logic [10:0] z
  );
    return {2'b11, z[9:0], uimm, 3'b111, 5'd1, 7'h57};
  endfunction

  function automatic logic [31:0] va(
    input logic [5:0] f6,
    input logic       vm,
    input logic [4:0] vs2,
    input logic [4:0] vs1,
    input logic [2:0] f3,
    input logic [4:0] vd
  );
    return {f6, vm, vs2, vs1, f3, vd, 7'h57};
  endfunction

  task automatic do_insn(
    input logic [31:0] i,
    input logic [63:0] r
  );
    insn_valid = 1'b1;
    insn       = i;
    rs1        = r;
    #1;
    for (int k = 0; k < 40 && !insn_ready; k++) begin
      @(negedge clk);
      #1;
    end
    chk("insn_ready", insn_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle();
    insn_valid = 1'b0;
    #1;
  endtask

  task automatic cfg(
    input logic [31:0] i,
    input logic [63:0] r
  );
    do_insn(i, r);
    idle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    insn_valid  = 1'b0;
    insn        = '0;
    rs1         = '0;
    issue_ready = 1'b1;
    done        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", insn_ready, 1'b1);
    chk("rst_ivalid", issue_valid, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_vill", vtype.vill, 1'b1);
    chk("rst_vl", vl, 8'd0);
    pulse_done();

    // e32 m2, AVL 100 -> VLMAX 8
    do_insn(vcfg(5'd1, zi(3'd2, 3'd1)), 64'd100);
    idle();
    chk("cfg_illegal", illegal, 1'b0);
    chk("cfg_noissue", issue_valid, 1'b0);
    chk("cfg_vl_t1", vl, 8'd0);
    @(negedge clk);
    #1;
    chk("cfg_vl_e32m2", vl, 8'd8);
    chk("cfg_vsew", vtype.vsew, EW32);
    chk("cfg_vlmul", vtype.vlmul, LMUL_2);
    chk("cfg_vill", vtype.vill, 1'b0);

    cfg(vcfg(5'd1, zi(3'd0, 3'd3)), 64'd100);
    chk("cfg_vl_e8m8", vl, 8'd100);
    cfg(vcfg(5'd0, zi(3'd0, 3'd0)), 64'd3);
    chk("cfg_vs1zero", vl, 8'd16);
    cfg(vcfgi(5'd5, zi(3'd1, 3'd7)), 64'd0);
    chk("cfgi_vl", vl, 8'd4);
    chk("cfgi_vlmul", vtype.vlmul, LMUL_1_2);
    cfg(vcfg(5'd1, zi(3'd3, 3'd5)), 64'd100);
    chk("vlmax0_vill", vtype.vill, 1'b1);
    chk("vlmax0_vl", vl, 8'd0);
    cfg(vcfg(5'd1, 11'h400 | zi(3'd2, 3'd0)), 64'd9);
    chk("rsvdbit_vill", vtype.vill, 1'b1);

    cfg(vcfg(5'd1, zi(3'd2, 3'd0)), 64'd100);
    cfg(vcfg(5'd1, zi(3'd0, 3'd4)), 64'd100);
    chk("lmulrsvd_vill", vtype.vill, 1'b1);
    chk("lmulrsvd_vl", vl, 8'd0);
    do_insn(va(OPVADD, 1'b1, 5'd2, 5'd6, OPIVV, 5'd4), 64'd0);
    idle();
    chk("vill_illegal", illegal, 1'b1);
    chk("vill_noissue", issue_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("illegal_pulse", illegal, 1'b0);

    // e32 m1 -> vl 4
    cfg(vcfg(5'd1, zi(3'd2, 3'd0)), 64'd100);
    do_insn({2'b10, 5'd0, 5'd2, 5'd1, 3'b111, 5'd1, 7'h57}, 64'd50);
    idle();
    chk("vsetvl_illegal", illegal, 1'b1);
    @(negedge clk);
    #1;
    chk("vsetvl_vl_kept", vl, 8'd4);

    do_insn(va(OPVADD, 1'b1, 5'd2, 5'd29, OPIVI, 5'd1), 64'd7);
    idle();
    chk("vi_valid", issue_valid, 1'b1);
    chk("vi_scalar", scalar_o, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("vi_vd", vd_o, 5'd1);
    chk("vi_vs2", vs2_o, 5'd2);
    chk("vi_f3", f3_o, OPIVI);
    chk("vi_vl", ivl, 8'd4);
    chk("vi_vsew", ivtype.vsew, EW32);
    do_insn(va(OPVSLL, 1'b1, 5'd4, 5'd7, OPIVX, 5'd3),
            64'h1234_5678_9ABC_DEF0);
    idle();
    chk("vx_valid", issue_valid, 1'b1);
    chk("vx_scalar", scalar_o, 64'h1234_5678_9ABC_DEF0);
    chk("vx_f6", f6_o, OPVSLL);
    do_insn(va(OPVADD, 1'b1, 5'd6, 5'd7, OPIVV, 5'd5), 64'hAA);
    idle();
    chk("vv_scalar", scalar_o, 64'd0);
    chk("vv_vs1", vs1_o, 5'd7);
    @(negedge clk);
    #1;
    repeat (4) pulse_done();

    // RAW hazard under LMUL_2
    cfg(vcfg(5'd1, zi(3'd2, 3'd1)), 64'd100);
    do_insn(va(OPVADD, 1'b1, 5'd2, 5'd6, OPIVV, 5'd4), 64'd0);
    idle();
    chk("raw_first_valid", issue_valid, 1'b1);
    do_insn(va(OPVSUB, 1'b1, 5'd4, 5'd6, OPIVV, 5'd8), 64'd0);
    idle();
    chk("raw_stall0", issue_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("raw_stall1", issue_valid, 1'b0);
    done = 1'b1;
    #1;
    chk("raw_stall_done", issue_valid, 1'b0);
    @(negedge clk);
    done = 1'b0;
    #1;
    chk("raw_release", issue_valid, 1'b1);
    chk("raw_vd", vd_o, 5'd8);
    @(negedge clk);
    #1;
    pulse_done();

    // FIFO full: five independent ops, four issue
    base = n_iss;
    for (int i = 0; i < 5; i++)
      do_insn(va(OPVADD, 1'b1, 5'd16, 5'd18, OPIVV,
                 5'(2 * i + 2)), 64'd0);
    idle();
    chk("full_stall", issue_valid, 1'b0);
    chk("full_ready", insn_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("full_count", n_iss - base, 4);
    pulse_done();
    chk("full_release", issue_valid, 1'b1);
    chk("full_rel_vd", vd_o, 5'd10);
    @(negedge clk);
    #1;
    chk("full_count5", n_iss - base, 5);

    // issue and done together: pop v6, push v12
    pulse_done();
    do_insn(va(OPVADD, 1'b1, 5'd16, 5'd18, OPIVV, 5'd12), 64'd0);
    idle();
    chk("sim_valid", issue_valid, 1'b1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    do_insn(va(OPVADD, 1'b1, 5'd6, 5'd18, OPIVV, 5'd20), 64'd0);
    idle();
    chk("sim_cleared", issue_valid, 1'b1);
    @(negedge clk);
    #1;
    pulse_done();
    do_insn(va(OPVADD, 1'b1, 5'd12, 5'd18, OPIVV, 5'd24), 64'd0);
    idle();
    chk("sim_set", issue_valid, 1'b0);
    pulse_done();
    chk("sim_set2", issue_valid, 1'b0);
    pulse_done();
    chk("sim_drain", issue_valid, 1'b1);
    @(negedge clk);
    #1;
    repeat (3) pulse_done();

    // alignment and mask checks
    cfg(vcfg(5'd1, zi(3'd2, 3'd2)), 64'd100);
    chk("m4_vl", vl, 8'd16);
    do_insn(va(OPVADD, 1'b1, 5'd4, 5'd8, OPIVV, 5'd2), 64'd0);
    idle();
    chk("m4_misalign", illegal, 1'b1);
    chk("m4_noissue", issue_valid, 1'b0);
    cfg(vcfg(5'd1, zi(3'd2, 3'd0)), 64'd100);
    do_insn(va(OPVMERGE, 1'b0, 5'd2, 5'd3, OPIVV, 5'd0), 64'd0);
    idle();
    chk("merge_v0", illegal, 1'b1);
    do_insn(va(6'b111111, 1'b1, 5'd2, 5'd3, OPIVV, 5'd1), 64'd0);
    idle();
    chk("bad_f6", illegal, 1'b1);
    do_insn(va(OPVMERGE, 1'b0, 5'd2, 5'd3, OPIVV, 5'd1), 64'd0);
    idle();
    chk("merge_ok", issue_valid, 1'b1);
    chk("merge_vm", vm_o, 1'b0);
    @(negedge clk);
    #1;

    // reset while v1 is in flight and a dependent op is held
    do_insn(va(OPVADD, 1'b1, 5'd1, 5'd3, OPIVV, 5'd4), 64'd0);
    idle();
    chk("pre_rst_stall", issue_valid, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", insn_ready, 1'b1);
    chk("mid_rst_ivalid", issue_valid, 1'b0);
    chk("mid_rst_vill", vtype.vill, 1'b1);
    pulse_done();
    cfg(vcfg(5'd1, zi(3'd2, 3'd0)), 64'd100);
    do_insn(va(OPVADD, 1'b1, 5'd1, 5'd3, OPIVV, 5'd4), 64'd0);
    idle();
    chk("post_rst_issue", issue_valid, 1'b1);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
